// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: grants the shared TX FIFO write port to whole report (hex display + CR LF) or RX echo messages.
// Define UART_ECHO_EN to compile in the echo path; without it only report messages are sent.
module uart_tx_scheduler #(
    parameter bit CRLF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic [15:0] display_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic        busy,
    output logic [7:0]  msg_count
);
    typedef enum logic [1:0] {IDLE, ECHO_WR, REP_WR} state_t;

    state_t      state_q;
    logic [15:0] last_disp_q, snap_q;
    logic [2:0]  idx_q;
    logic [7:0]  msg_count_q;
    logic        rep_pend, grant_rep, grant_echo;
    logic [3:0]  nib;
    logic [7:0]  hex_char, rep_char;

    localparam logic [2:0] LAST_IDX = CRLF_EN ? 3'd5 : 3'd3;

    assign rep_pend = display_in != last_disp_q;

`ifdef UART_ECHO_EN
    logic [7:0] echo_q;
    logic       last_grant_q;
    // last_grant_q: 0 = echo, 1 = report; only contested grants update it
    assign grant_echo = !rx_empty && (!rep_pend || last_grant_q);
    assign grant_rep  = rep_pend && (rx_empty || !last_grant_q);
    assign rd_uart    = clk_en && state_q == IDLE && grant_echo;
    assign w_data     = state_q == REP_WR ? rep_char : state_q == ECHO_WR ? echo_q : 8'h00;
`else
    logic unused_rx;
    assign unused_rx  = ^{rx_data, rx_empty};
    assign grant_echo = 1'b0;
    assign grant_rep  = rep_pend;
    assign rd_uart    = 1'b0;
    assign w_data     = state_q == REP_WR ? rep_char : 8'h00;
`endif

    assign nib      = idx_q == 3'd0 ? snap_q[15:12] :
                      idx_q == 3'd1 ? snap_q[11:8]  :
                      idx_q == 3'd2 ? snap_q[7:4]   : snap_q[3:0];
    assign hex_char = nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    assign rep_char = idx_q == 3'd4 ? 8'h0D : idx_q == 3'd5 ? 8'h0A : hex_char;

    assign wr_uart   = clk_en && !tx_full && state_q != IDLE;
    assign busy      = state_q != IDLE;
    assign msg_count = msg_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_disp_q  <= 16'h0000;
            snap_q       <= 16'h0000;
            idx_q        <= 3'd0;
            msg_count_q  <= 8'h00;
`ifdef UART_ECHO_EN
            echo_q       <= 8'h00;
            last_grant_q <= 1'b0;
`endif
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (grant_rep) begin
                        snap_q      <= display_in;
                        last_disp_q <= display_in;
                        idx_q       <= 3'd0;
                        state_q     <= REP_WR;
`ifdef UART_ECHO_EN
                        if (!rx_empty) last_grant_q <= 1'b1;
`endif
                    end
`ifdef UART_ECHO_EN
                    else if (grant_echo) begin
                        echo_q  <= rx_data;
                        state_q <= ECHO_WR;
                        if (rep_pend) last_grant_q <= 1'b0;
                    end
`endif
                end
                REP_WR: begin
                    if (!tx_full) begin
                        if (idx_q == LAST_IDX) begin
                            msg_count_q <= msg_count_q + 8'd1;
                            state_q     <= IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_ECHO_EN
                ECHO_WR: if (!tx_full) state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencer and arbiter for the shared UART transmit FIFO in the Singularis top level. Two requesters compete for the single `w_data`/`wr_uart` write port: a report engine that sends the processor's 16-bit display value as ASCII hex plus CR LF whenever it changes, and an echo path that pops received bytes from the RX FIFO and re-transmits them. The block sits between `Top_processor`'s display output, the terminal's RX FIFO read side and TX FIFO write side, and grants the port one whole message at a time.

## Interface
Parameters:
- `CRLF_EN` — default 1 — 1: append 0x0D 0x0A after the 4 hex digits; 0: message is the 4 digits only.

Ports:
- `clk` — in — 1 — system clock; single clock domain.
- `reset_n` — in — 1 — reset; asynchronous and active-low.
- `clk_en` — in — 1 — clock enable; state, counters and registers advance only on cycles with `clk_en=1`.
- `display_in` — in — 16 — processor display value to report.
- `rx_data` — in — 8 — RX FIFO head byte; first-word-fall-through, valid while `rx_empty=0`.
- `rx_empty` — in — 1 — RX FIFO empty.
- `rd_uart` — out — 1 — RX FIFO pop, one cycle.
- `tx_full` — in — 1 — TX FIFO full.
- `wr_uart` — out — 1 — TX FIFO push, one cycle.
- `w_data` — out — 8 — byte pushed with `wr_uart`.
- `busy` — out — 1 — high when state is not IDLE.
- `msg_count` — out — 8 — count of completed report messages.

## Operation
- States: IDLE, ECHO_WR, REP_WR. Report index register `idx` (3 bits).
- Report pending: `rep_pend = (display_in != last_disp)`. `last_disp` resets to 0x0000.
- Echo pending: `rx_empty=0`.
- Arbitration happens in IDLE only.
  - One requester pending: that requester is granted.
  - Both pending: the one not granted last wins. `last_grant` resets to ECHO, so the report wins the first tie.
- Echo grant:
  - `rd_uart=1` for that cycle and `echo_q <= rx_data`; go to ECHO_WR.
  - In ECHO_WR, the first enabled cycle with `tx_full=0` gives `wr_uart=1`, `w_data=echo_q`, then IDLE.
- Report grant:
  - `snap <= display_in`, `last_disp <= display_in`, `idx <= 0`; go to REP_WR.
  - Each enabled cycle with `tx_full=0` pushes char `idx` and increments `idx`.
  - idx 0–3: nibbles `snap[15:12]`..`snap[3:0]`. 0–9 maps to 0x30–0x39; A–F maps to 0x41–0x46 (uppercase).
  - idx 4 = 0x0D, idx 5 = 0x0A.
  - After the last char (idx 5, or idx 3 when `CRLF_EN=0`): `msg_count` increments (wraps 255→0) and the state returns to IDLE.
- `display_in` changes during a message do not alter `snap`. Intermediate values are coalesced: the next message reports the value present when it is granted.
- A report for a value equal to `last_disp` is never sent (no change, no message).
- `tx_full=1` stalls in place: no push, state and `idx` hold. There is no timeout.

## Timing
- `wr_uart` and `rd_uart` are combinational from registered state, `clk_en`, `tx_full` and `rx_empty`. Each is high for at most one cycle per transfer and only when `clk_en=1`.
- `w_data` is registered/decoded from `snap`/`idx`/`echo_q`. It is valid in every cycle `wr_uart=1` and is 0x00 in IDLE.
- Echo latency: pop in the IDLE grant cycle; push on the next enabled cycle if not full. Minimum 2 enabled cycles per echoed byte.
- Report latency: grant in the enabled cycle after the change is visible; the first digit is pushed on the next enabled cycle. With `tx_full=0` throughout, a 6-byte message takes 1+6 enabled cycles.
- A new grant is made no earlier than the enabled cycle after returning to IDLE, i.e. one idle cycle between messages.
- Reset (async assert, at any time including mid-message) values:
  - state IDLE, `rd_uart=0`, `wr_uart=0`, `w_data=0x00`, `busy=0`, `msg_count=0`
  - `last_disp=0`, `snap=0`, `echo_q=0`, `idx=0`, `last_grant=ECHO`
  - A partially sent message is abandoned, not resumed.

## Configuration
- `UART_ECHO_EN` defined: echo path, ECHO_WR state and arbitration are compiled in, as described above.
- `UART_ECHO_EN` not defined:
  - Echo logic is removed and `rd_uart` is tied 0; `rx_data` and `rx_empty` are ignored.
  - The report engine is the only requester and is granted whenever `rep_pend=1`.
  - Report timing and all other behaviour are unchanged.

## Test plan
- Report after reset: after reset, `display_in=0x12AF`, `clk_en=1`, `tx_full=0` → pushes 0x31 0x32 0x41 0x46 0x0D 0x0A; `msg_count=1`; `display_in` held → no further pushes.
- Echo: RX FIFO holds 0x55, `display_in=0x0000` → one `rd_uart` pulse, then one push of 0x55; `busy` returns to 0.
- Tie: `display_in` becomes 0x0001 and RX byte 0x7A arrives in the same cycle → report "0001\r\n" first, then 0x7A. A second simultaneous pair (`display_in=0x0002`, RX byte 0x7B) → 0x7B first, then "0002\r\n".
- Back-pressure: `tx_full=1` for 10 cycles after the second digit → no pushes and `idx` holds; on release the remaining 4 bytes follow in consecutive enabled cycles.
- `clk_en` at 1-in-4 with `display_in=0xBEEF` → one push per enabled cycle only, all pushes aligned to `clk_en=1`; mid-message `reset_n=0` → outputs drop to reset values immediately and no further bytes are pushed; after release, a nonzero `display_in` is reported again from digit 0.
- Compiled without `UART_ECHO_EN`, RX byte 0x41 present → `rd_uart` stays 0; report path behaves as in the first scenario.
